// File: rtl/replay_accumulator_if.sv
// Stream bundle for replay_accumulator: input item channel plus output sum channel.
interface replay_accumulator_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned OW = 10
);
  logic [W-1:0]  idat;
  logic          ilast;
  logic          ifin;
  logic          ivld;
  logic          irdy;
  logic [OW-1:0] odat;
  logic          olast;
  logic          ovld;
  logic          ordy;

  // Accumulator side: consumes items, produces sums.
  modport slave (
    input  idat, ilast, ifin, ivld, ordy,
    output irdy, odat, olast, ovld
  );

  // Environment side: produces items, consumes sums.
  modport master (
    output idat, ilast, ifin, ivld, ordy,
    input  irdy, odat, olast, ovld
  );
endinterface

// File: rtl/replay_accumulator.sv
// Folds REP replayed passes of a LEN-item sequence into one LEN-item sequence of sums.
module replay_accumulator #(
  parameter int unsigned LEN = 4,
  parameter int unsigned REP = 3,
  parameter int unsigned W   = 8,
  parameter int unsigned OW  = W + $clog2(REP)
) (
  input logic                 clk,
  input logic                 rst_n,
  replay_accumulator_if.slave bus,
  output logic                err
);

  if (LEN == 0) begin : g_bad_len
    $error("replay_accumulator: LEN must be at least 1");
  end
  if (REP == 0) begin : g_bad_rep
    $error("replay_accumulator: REP must be at least 1");
  end
  if (OW < W) begin : g_bad_ow
    $error("replay_accumulator: OW must be at least W");
  end

  localparam int unsigned PosW  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int unsigned PassW = (REP > 1) ? $clog2(REP) : 1;
  // Memory is sized to the full index range so the position counter indexes it exactly.
  localparam int unsigned MemD  = 2 ** PosW;
  localparam logic [PosW-1:0]  PosMax  = PosW'(LEN - 1);
  localparam logic [PassW-1:0] PassMax = PassW'(REP - 1);

  logic [PosW-1:0]  pos_q, pos_d;
  logic [PassW-1:0] pass_q, pass_d;
  logic             ovld_q, ovld_d;
  logic             olast_q, olast_d;
  logic [OW-1:0]    odat_q, odat_d;
  logic             err_q, err_d;
  logic [OW-1:0]    mem_q [MemD];
  logic [OW-1:0]    mem_d [MemD];

  logic          final_pass;
  logic          at_end;
  logic          irdy;
  logic          accept;
  logic [OW-1:0] ext;
  logic [OW-1:0] base;
  logic [OW-1:0] sum;

  assign final_pass = (pass_q == PassMax);
  assign at_end     = (pos_q == PosMax);
  // Earlier passes never stall; the final pass only needs the output register free.
  assign irdy       = !final_pass || !ovld_q || bus.ordy;
  assign accept     = bus.ivld && irdy;

  assign ext  = OW'(signed'(bus.idat));
  // Pass 0 starts a fresh sum; the memory is read asynchronously, so a write from the
  // previous edge is already visible here and same-address back-to-back items need no bubble.
  assign base = (pass_q == '0) ? '0 : mem_q[pos_q];
  assign sum  = base + ext;

  // Next-state: counters, accumulation memory, output register and framing check.
  always_comb begin
    pos_d   = pos_q;
    pass_d  = pass_q;
    ovld_d  = ovld_q;
    olast_d = olast_q;
    odat_d  = odat_q;
    err_d   = err_q;
    mem_d   = mem_q;

    if (ovld_q && bus.ordy) begin
      ovld_d = 1'b0;
    end

    if (accept) begin
      if (final_pass) begin
        odat_d  = sum;
        olast_d = at_end;
        ovld_d  = 1'b1;
      end else begin
        mem_d[pos_q] = sum;
      end

      // Flags are checked only; the counters alone decide where data goes.
      if ((bus.ilast != at_end) || (bus.ifin != (at_end && final_pass))) begin
        err_d = 1'b1;
      end

      if (at_end) begin
        pos_d  = '0;
        pass_d = final_pass ? '0 : pass_q + PassW'(1);
      end else begin
        pos_d = pos_q + PosW'(1);
      end
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q  <= '0;
      pass_q <= '0;
      ovld_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      pass_q <= pass_d;
      ovld_q <= ovld_d;
      err_q  <= err_d;
    end
  end

  // Datapath state is never reset: output data is qualified by ovld and pass 0 overwrites memory.
  always_ff @(posedge clk) begin
    odat_q  <= odat_d;
    olast_q <= olast_d;
    mem_q   <= mem_d;
  end

  assign bus.irdy  = irdy;
  assign bus.odat  = odat_q;
  assign bus.olast = olast_q;
  assign bus.ovld  = ovld_q;
  assign err       = err_q;

endmodule
